// File: rtl/programmable_divider_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// MODE encoding and the channel-index width used by the LOAD_CH port.
package programmable_divider_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    // A single-channel build still gets a 1-bit LOAD_CH so the port never collapses.
    function automatic int ch_idx_w(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/programmable_divider_channel.sv
// One divider channel: applied/shadow divisor, counter and square toggle.
// Shadow divisor is applied at terminal count so a retune never produces a runt period.
module divider_channel
    import programmable_divider_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(1000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    input  logic             mode,
    output logic             tick,
    output logic             divided_clk,
    output logic             active
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] d_q, s_q, c_q;
    logic [WIDTH-1:0] d_n, s_n, c_n;
    logic [WIDTH-1:0] eff_s;
    logic             q_q, q_n;
    logic             tick_q, tick_n;
    logic             dclk_q, dclk_n;
    logic             tc;

    // A write landing in the same cycle as SYNC or TC is seen through eff_s.
    always_comb begin
        eff_s  = load ? load_div : s_q;
        tc     = en && (d_q != '0) && (c_q == d_q - ONE);
        d_n    = d_q;
        s_n    = eff_s;
        c_n    = c_q;
        q_n    = q_q;
        tick_n = 1'b0;

        if (sync) begin
            d_n = eff_s;
            c_n = '0;
            q_n = 1'b0;
        end else if (d_q == '0) begin
            if (load) begin
                d_n = load_div;
                c_n = '0;
                q_n = 1'b0;
            end
        end else if (en) begin
            if (tc) begin
                tick_n = 1'b1;
                d_n    = eff_s;
                c_n    = '0;
                q_n    = (eff_s == '0) ? 1'b0 : ~q_q;
            end else begin
                c_n = c_q + ONE;
            end
        end

        dclk_n = (mode == MODE_PULSE) ? tick_n : q_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q    <= RESET_DIV;
            s_q    <= RESET_DIV;
            c_q    <= '0;
            q_q    <= 1'b0;
            tick_q <= 1'b0;
            dclk_q <= 1'b0;
        end else begin
            d_q    <= d_n;
            s_q    <= s_n;
            c_q    <= c_n;
            q_q    <= q_n;
            tick_q <= tick_n;
            dclk_q <= dclk_n;
        end
    end

    assign tick        = tick_q;
    assign divided_clk = dclk_q;
    assign active      = (d_q != '0);

endmodule

// File: rtl/programmable_divider.sv
// Multi-channel programmable divider: decodes the shared LOAD bus into
// per-channel write strobes and fans SYNC out to every channel.
module programmable_divider
    import programmable_divider_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 1000
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [CHANNELS-1:0]              EN,
    input  logic                             SYNC,
    input  logic                             LOAD,
    input  logic [ch_idx_w(CHANNELS)-1:0]    LOAD_CH,
    input  logic [WIDTH-1:0]                 LOAD_DIV,
    input  logic [CHANNELS-1:0]              MODE,
    output logic [CHANNELS-1:0]              TICK,
    output logic [CHANNELS-1:0]              DIVIDED_CLK,
    output logic [CHANNELS-1:0]              ACTIVE
);

    localparam int CH_W = ch_idx_w(CHANNELS);

    logic [CHANNELS-1:0] load_strobe;

    // Addresses at or beyond CHANNELS match no channel, so those writes vanish.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign load_strobe[gi] = LOAD && (LOAD_CH == CH_W'(gi));

        divider_channel #(
            .WIDTH     (WIDTH),
            .RESET_DIV (WIDTH'(RESET_DIV))
        ) u_channel (
            .clk         (CLK),
            .rst         (RST),
            .en          (EN[gi]),
            .sync        (SYNC),
            .load        (load_strobe[gi]),
            .load_div    (LOAD_DIV),
            .mode        (MODE[gi]),
            .tick        (TICK[gi]),
            .divided_clk (DIVIDED_CLK[gi]),
            .active      (ACTIVE[gi])
        );
    end

endmodule

// File: doc/programmable_divider.md
PROGRAMMABLE_DIVIDER -- requirements
Module: programmable_divider

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter WIDTH, default 16: width of each channel's divisor and counter, range 2..32.
REQ-003 Parameter RESET_DIV, default 1000: divisor loaded into every channel at reset, range 0..2^WIDTH-1.
REQ-004 CLK  input  1: single clock; all logic on rising edge.
REQ-005 RST  input  1: asynchronous, active-high reset.
REQ-006 EN  input  CHANNELS: per-channel count enable; 0 freezes that channel's counter and outputs.
REQ-007 SYNC  input  1: one-cycle restart strobe for all channels.
REQ-008 LOAD  input  1: one-cycle divisor write strobe.
REQ-009 LOAD_CH  input  clog2(CHANNELS), minimum 1: channel addressed by LOAD.
REQ-010 LOAD_DIV  input  WIDTH: divisor value written by LOAD.
REQ-011 MODE  input  CHANNELS: per-channel output mode; 0 = PULSE, 1 = SQUARE.
REQ-012 TICK  output  CHANNELS: registered one-cycle pulse at each channel's terminal count.
REQ-013 DIVIDED_CLK  output  CHANNELS: registered per-channel divided output; waveform set by MODE.
REQ-014 ACTIVE  output  CHANNELS: 1 when the channel's applied divisor is nonzero.

Function
REQ-015 Each channel holds an applied divisor D, a shadow divisor S, a counter C (WIDTH bits) and a square toggle Q.
REQ-016 When EN=1 and D>0: C increments each cycle; C==D-1 is terminal count (TC), and at TC C wraps to 0.
REQ-017 TICK is registered as EN & (D>0) & TC: high for exactly one cycle per D enabled cycles; with D=1, TICK stays high continuously while enabled.
REQ-018 Q toggles at each TC, giving a 50% duty period of 2*D enabled cycles.
REQ-019 DIVIDED_CLK shall equal TICK when MODE=PULSE and Q when MODE=SQUARE; a MODE change takes effect on the next cycle and does not alter Q.
REQ-020 When EN=0: C, Q and S are held; TICK is 0; DIVIDED_CLK holds Q in SQUARE mode and is 0 in PULSE mode.
REQ-021 LOAD writes LOAD_DIV into S of channel LOAD_CH; if LOAD_CH>=CHANNELS, the write is ignored.
REQ-022 S is copied into D at the next TC, so the period in progress completes with the old divisor (glitch-free retune).
REQ-023 If D==0 when LOAD occurs, S is copied into D immediately and C and Q are cleared.
REQ-024 Writing S=0 parks the channel at its next TC: C and Q are cleared, TICK is 0 and ACTIVE is 0.
REQ-025 SYNC clears C and Q in all channels and copies S into D in all channels, in the same cycle.
REQ-026 LOAD and SYNC in the same cycle: the new LOAD_DIV is applied to D by the SYNC.
REQ-027 LOAD and TC of the addressed channel in the same cycle: LOAD_DIV is applied at that TC.
REQ-028 SYNC has priority over TC; TC does not produce a TICK in a cycle where SYNC is asserted.

Reset
REQ-029 RST=1 asynchronously sets D=S=RESET_DIV and clears C, Q, TICK and DIVIDED_CLK in every channel.
REQ-030 During reset, ACTIVE equals (RESET_DIV!=0).
REQ-031 After RST is released, the first TICK on an enabled channel occurs D cycles after the first enabled edge.
REQ-032 Reset asserted mid-period discards the in-progress count and any pending shadow value.

Structure
REQ-033 A shared package holds the MODE_PULSE/MODE_SQUARE constants and the channel-index width function.
REQ-034 One sub-module, divider_channel, implements REQ-015..REQ-028 for one channel.
REQ-035 The top level instantiates CHANNELS copies of divider_channel and decodes LOAD/LOAD_CH into per-channel write strobes.

Verification
REQ-036 Reset defaults: RESET_DIV=4, EN=1, MODE=PULSE -> TICK pulses at cycles 4, 8, 12 after reset release, each 1 cycle wide.
REQ-037 SQUARE mode: D=3, MODE=SQUARE -> DIVIDED_CLK is 3 cycles high, 3 cycles low, repeating.
REQ-038 Retune: with D=10, LOAD 4 at C=2 -> next TICK at C=9, following ticks every 4 cycles, no runt pulse.
REQ-039 Park and wake: LOAD 0 -> ACTIVE falls after the current TC; then LOAD 5 -> counting restarts immediately and the first TICK arrives 5 cycles later.
REQ-040 Simultaneous events: LOAD 6 with SYNC in the same cycle on channel 1 while channel 0 runs D=8 -> both counters restart at 0; channel 1 ticks every 6 cycles, channel 0 every 8.
REQ-041 Async reset mid-count plus EN freeze: EN=0 for 5 cycles holds C and TICK=0, and the period stretches by 5 cycles; RST pulsed between edges clears outputs immediately, without waiting for a clock edge.
